// File: rtl/bs_pkg.sv
// Shared types and default sizes for the bit-serial serializer.
package bs_pkg;

    // Default operand width and default number of sign-extension bits
    localparam int BS_W_DEFAULT   = 8;
    localparam int BS_EXT_DEFAULT = 8;

    // Frame sequencing: wait for a word, emit the start strobe, then shift bits out
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } bs_state_t;

endpackage

// File: rtl/bs_serializer.sv
// Parallel-to-serial converter for two's-complement operands.
// A captured word is emitted LSB first and followed by EXT copies of its sign
// bit. A one-cycle start strobe precedes every frame so that downstream
// bit-serial stages can clear their state. start, sout, last and busy all come
// straight from flops; only din_ready is combinational.
module bs_serializer
    import bs_pkg::*;
#(
    parameter int W   = BS_W_DEFAULT,
    parameter int EXT = BS_EXT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         abort,
    output logic         start,
    output logic         sout,
    output logic         last,
    output logic         busy
);

    // Frame length and bit counter sizing. The counter only runs from 0 to
    // L-1, so it can never wrap inside a frame.
    localparam int L  = W + EXT;
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(L - 1);

    bs_state_t     state, state_n;
    logic [W-1:0]  shreg, shreg_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          start_r, start_n;
    logic          sout_r, sout_n;
    logic          last_r, last_n;
    logic          busy_r, busy_n;

    // A word is accepted only while idle and not being told to abort
    assign din_ready = (state == IDLE) && !abort;

    // Next-state logic. The output flops are loaded with the values that belong
    // to the state being entered. The bit sent in a SHIFT cycle is therefore
    // taken from bit 0 of the register while it is being shifted. The shift is
    // arithmetic, so once the W data bits are gone only sign copies remain.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        start_n = 1'b0;
        sout_n  = 1'b0;
        last_n  = 1'b0;

        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        state_n = START;
                        shreg_n = din;
                        cnt_n   = '0;
                        start_n = 1'b1;
                    end
                end
                START: begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    sout_n  = shreg[0];
                    shreg_n = {shreg[W-1], shreg[W-1:1]};
                end
                SHIFT: begin
                    if (cnt == LAST_BIT) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        sout_n  = shreg[0];
                        shreg_n = {shreg[W-1], shreg[W-1:1]};
                        last_n  = (cnt_n == LAST_BIT);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    // State, datapath and output registers. Reset overrides abort and any
    // handshake and truncates a running frame without a last pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            start_r <= 1'b0;
            sout_r  <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            start_r <= start_n;
            sout_r  <= sout_n;
            last_r  <= last_n;
            busy_r  <= busy_n;
        end
    end

    assign start = start_r;
    assign sout  = sout_r;
    assign last  = last_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_bs_serializer.sv
// Directed bench for bs_serializer: a W=4/EXT=4 instance and a W=8/EXT=0 instance.
module tb_bs_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       abort = 1'b0;
    logic       start, sout, last, busy;

    logic [7:0] b_din = '0;
    logic       b_din_valid = 1'b0;
    logic       b_din_ready;
    logic       b_abort = 1'b0;
    logic       b_start, b_sout, b_last, b_busy;

    int         assertCount = 0;
    int         failCount   = 0;
    int         cycle       = 0;
    int         startCycle0 = 0;
    logic [7:0] bits;
    logic [7:0] bExp;

    bs_serializer #(.W(4), .EXT(4)) dutA (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .abort(abort), .start(start),
        .sout(sout), .last(last), .busy(busy)
    );

    bs_serializer #(.W(8), .EXT(0)) dutB (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid),
        .din_ready(b_din_ready), .abort(b_abort), .start(b_start),
        .sout(b_sout), .last(b_last), .busy(b_busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic ab);
        din_valid = v;
        din       = d;
        abort     = ab;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial two's complementer: copy bits up to and including the first 1, invert the rest
    function automatic logic [7:0] complement(input logic [7:0] v);
        logic seen;
        logic [7:0] r;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r[i] = seen ? ~v[i] : v[i];
            seen = seen | v[i];
        end
        return r;
    endfunction

    // Eight SHIFT cycles of dutA followed by the return to IDLE
    task automatic shiftBits(input string tag, input logic [7:0] expv, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            got[i] = sout;
            checkOutput($sformatf("%s_sout%0d", tag, i), sout, expv[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), last, (i == 7));
            checkOutput($sformatf("%s_start%0d", tag, i), start, 0);
            checkOutput($sformatf("%s_busy%0d", tag, i), busy, 1);
        end
        tick();
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_sout"}, sout, 0);
        checkOutput({tag, "_idle_last"}, last, 0);
        checkOutput({tag, "_idle_ready"}, din_ready, 1);
    endtask

    // Handshake, START cycle, then the full frame on dutA
    task automatic runFrame(input string tag, input logic [3:0] d, input logic [7:0] expv, output logic [7:0] got);
        applyStimulus(1'b1, d, 1'b0);
        checkOutput({tag, "_ready"}, din_ready, 1);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput({tag, "_start"}, start, 1);
        checkOutput({tag, "_start_busy"}, busy, 1);
        checkOutput({tag, "_start_sout"}, sout, 0);
        checkOutput({tag, "_start_last"}, last, 0);
        checkOutput({tag, "_start_ready"}, din_ready, 0);
        shiftBits(tag, expv, got);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("rst_start", start, 0);
        checkOutput("rst_sout", sout, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rstB_busy", b_busy, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", din_ready, 1);
        checkOutput("rst_release_readyB", b_din_ready, 1);

        // din = 0011
        runFrame("f3", 4'b0011, 8'h03, bits);

        // din = 1011 (-5), then negate serially to +5
        runFrame("fm5", 4'b1011, 8'hFB, bits);
        checkOutput("negate_m5", complement(bits), 8'h05);

        // din_valid held high: busy-time words are ignored, frames every L+2 cycles
        applyStimulus(1'b1, 4'b0101, 1'b0);
        checkOutput("cont_ready", din_ready, 1);
        tick();
        startCycle0 = cycle;
        checkOutput("cont_start0", start, 1);
        applyStimulus(1'b1, 4'b1110, 1'b0);
        checkOutput("cont_busy_ready", din_ready, 0);
        shiftBits("cont0", 8'h05, bits);
        tick();
        checkOutput("cont_start1", start, 1);
        checkOutput("cont_gap", cycle - startCycle0, 10);
        applyStimulus(1'b0, 4'h0, 1'b0);
        shiftBits("cont1", 8'hFE, bits);

        // Abort during bit 3
        applyStimulus(1'b1, 4'b0011, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("ab_start", start, 1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("ab_bit3", sout, 0);
        checkOutput("ab_busy3", busy, 1);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        checkOutput("ab_start_after", start, 0);
        checkOutput("ab_sout_after", sout, 0);
        checkOutput("ab_last_after", last, 0);
        checkOutput("ab_busy_after", busy, 0);
        checkOutput("ab_ready_blocked", din_ready, 0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        tick();
        checkOutput("ab_no_capture", busy, 0);
        checkOutput("ab_no_start", start, 0);
        checkOutput("ab_ready", din_ready, 1);
        runFrame("ab_new", 4'b1011, 8'hFB, bits);

        // Reset during SHIFT
        applyStimulus(1'b1, 4'b1111, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("rs_bit2", sout, 1);
        rst = 1'b1;
        tick();
        checkOutput("rs_start", start, 0);
        checkOutput("rs_sout", sout, 0);
        checkOutput("rs_last", last, 0);
        checkOutput("rs_busy", busy, 0);
        applyStimulus(1'b1, 4'b0011, 1'b0);
        tick();
        checkOutput("rs_hold_start", start, 0);
        checkOutput("rs_hold_last", last, 0);
        checkOutput("rs_hold_busy", busy, 0);
        rst = 1'b0;
        #1;
        checkOutput("rs_ready", din_ready, 1);
        runFrame("rs_new", 4'b0011, 8'h03, bits);

        // W=8, EXT=0, din = 0x80
        bExp = 8'h80;
        b_din_valid = 1'b1;
        b_din = 8'h80;
        #1;
        checkOutput("B_ready", b_din_ready, 1);
        tick();
        b_din_valid = 1'b0;
        checkOutput("B_start", b_start, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("B_sout%0d", i), b_sout, bExp[i]);
            checkOutput($sformatf("B_last%0d", i), b_last, (i == 7));
        end
        tick();
        checkOutput("B_idle_busy", b_busy, 0);
        checkOutput("B_idle_last", b_last, 0);
        checkOutput("B_idle_ready", b_din_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
